// File: rtl/mc6502_interrupt_sequencer.sv
// mc6502_interrupt_sequencer
//
// Runs the 6502 interrupt / reset entry sequence on behalf of the core:
// pushes PCH, PCL and PSR onto the stack page, then fetches the two vector
// bytes and hands them to the register file. The sequencer also holds the
// NMI falling-edge detector and the pending-NMI latch.
//
// Sequence shapes (one cen cycle per state):
//   IRQ / BRK / NMI : PUSH_PCH -> PUSH_PCL -> PUSH_PSR -> VEC_LO -> VEC_HI
//   reset           : VEC_LO -> VEC_HI (no stack traffic)
//
// Bus handshake: this block is the bus master for the duration of a
// sequence. mem_read / mem_write are asserted for exactly the states that
// own the bus and are never both high. They are meaningful only in cycles
// where cen=1; downstream logic qualifies every strobe with cen, and
// mem_rdata must be valid in the same cen cycle as mem_read.
//
// dbg_state_o and dbg_nmi_pending_o expose the FSM state and the pending
// NMI latch so checkers can observe them directly.

module mc6502_interrupt_sequencer #(
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        cen,
    input  logic        i_irq_x,
    input  logic        i_nmi_x,
    input  logic        sync,
    input  logic        brk,
    input  logic        rf_i,
    input  logic [7:0]  rf_s,
    input  logic [15:0] rf_pc,
    input  logic [7:0]  rf_psr,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        rf_set_i,
    output logic        rf_s_dec,
    output logic        rf_pcl_we,
    output logic        rf_pch_we,
    output logic [7:0]  rf_data,
    output logic [2:0]  dbg_state_o,
    output logic        dbg_nmi_pending_o
);

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PUSH_PCH = 3'd1;
    localparam logic [2:0] ST_PUSH_PCL = 3'd2;
    localparam logic [2:0] ST_PUSH_PSR = 3'd3;
    localparam logic [2:0] ST_VEC_LO   = 3'd4;
    localparam logic [2:0] ST_VEC_HI   = 3'd5;

    // Vector selection encoding
    localparam logic [1:0] VEC_NMI = 2'd0;
    localparam logic [1:0] VEC_RES = 2'd1;
    localparam logic [1:0] VEC_IRQ = 2'd2;

    // Low bytes of the vector table entries (high byte is always FF)
    localparam logic [7:0] VEC_NMI_LO = 8'hFA;
    localparam logic [7:0] VEC_RES_LO = 8'hFC;
    localparam logic [7:0] VEC_IRQ_LO = 8'hFE;

    logic [2:0] state_q, state_d;
    logic [1:0] vector_q, vector_d;
    logic       b_flag_q, b_flag_d;
    logic       nmi_pending_q, nmi_pending_d;
    logic       nmi_prev_q, nmi_prev_d;

    logic       nmi_edge;
    logic       nmi_clear;
    logic       start_req;
    logic [15:0] vec_addr;
    logic [7:0]  psr_push;

    // A falling edge is seen when the previous sample was high and the
    // current one is low; only evaluated on cen cycles via the register load.
    assign nmi_edge  = nmi_prev_q & ~i_nmi_x;

    // Acceptance condition at an instruction boundary. IRQ is a level and is
    // not latched; BRK is unconditional and ignores the I flag.
    assign start_req = nmi_pending_q | brk | (~i_irq_x & ~rf_i);

    // Next-state logic for the FSM, vector select, B flag and NMI latch
    always_comb begin
        state_d    = state_q;
        vector_d   = vector_q;
        b_flag_d   = b_flag_q;
        nmi_prev_d = i_nmi_x;
        nmi_clear  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync && start_req) begin
                    state_d  = ST_PUSH_PCH;
                    b_flag_d = brk;
                    vector_d = nmi_pending_q ? VEC_NMI : VEC_IRQ;
                end
            end
            ST_PUSH_PCH: begin
                state_d = ST_PUSH_PCL;
            end
            ST_PUSH_PCL: begin
                state_d = ST_PUSH_PSR;
            end
            ST_PUSH_PSR: begin
                state_d = ST_VEC_LO;
                // An NMI that arrived during the pushes hijacks the vector
                // fetch; the pushed B flag keeps its original meaning.
                if (nmi_pending_q) begin
                    vector_d = VEC_NMI;
                end
                // Leaving PUSH_PSR towards the NMI vector consumes the latch.
                nmi_clear = nmi_pending_q | (vector_q == VEC_NMI);
            end
            ST_VEC_LO: begin
                state_d = ST_VEC_HI;
            end
            ST_VEC_HI: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh edge wins over the clear so that it is not lost.
        if (nmi_edge) begin
            nmi_pending_d = 1'b1;
        end else if (nmi_clear) begin
            nmi_pending_d = 1'b0;
        end else begin
            nmi_pending_d = nmi_pending_q;
        end
    end

    // State registers: reset overrides cen and any sequence in progress
    always_ff @(posedge clk) begin
        if (!rst_x) begin
            state_q       <= ST_VEC_LO;
            vector_q      <= VEC_RES;
            b_flag_q      <= 1'b0;
            nmi_pending_q <= 1'b0;
            nmi_prev_q    <= 1'b1;
        end else if (cen) begin
            state_q       <= state_d;
            vector_q      <= vector_d;
            b_flag_q      <= b_flag_d;
            nmi_pending_q <= nmi_pending_d;
            nmi_prev_q    <= nmi_prev_d;
        end
    end

    // Vector address for the low byte; the high byte is at +1
    always_comb begin
        vec_addr = {8'hFF, VEC_IRQ_LO};
        case (vector_q)
            VEC_NMI: vec_addr = {8'hFF, VEC_NMI_LO};
            VEC_RES: vec_addr = {8'hFF, VEC_RES_LO};
            default: vec_addr = {8'hFF, VEC_IRQ_LO};
        endcase
    end

    // PSR image written to the stack: bit 5 forced high, bit 4 is the B flag
    always_comb begin
        psr_push    = rf_psr;
        psr_push[5] = 1'b1;
        psr_push[4] = b_flag_q;
    end

    // Output decode, purely from the current state and held registers
    always_comb begin
        mem_addr  = 16'h0000;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 8'h00;
        rf_set_i  = 1'b0;
        rf_s_dec  = 1'b0;
        rf_pcl_we = 1'b0;
        rf_pch_we = 1'b0;

        case (state_q)
            ST_PUSH_PCH: begin
                mem_write = 1'b1;
                mem_addr  = {STACK_PAGE, rf_s};
                mem_wdata = rf_pc[15:8];
                rf_s_dec  = 1'b1;
            end
            ST_PUSH_PCL: begin
                mem_write = 1'b1;
                mem_addr  = {STACK_PAGE, rf_s};
                mem_wdata = rf_pc[7:0];
                rf_s_dec  = 1'b1;
            end
            ST_PUSH_PSR: begin
                mem_write = 1'b1;
                mem_addr  = {STACK_PAGE, rf_s};
                mem_wdata = psr_push;
                rf_s_dec  = 1'b1;
                rf_set_i  = 1'b1;
            end
            ST_VEC_LO: begin
                mem_read  = 1'b1;
                mem_addr  = vec_addr;
                rf_pcl_we = 1'b1;
                // Reset never passes through PUSH_PSR, so I is set here.
                rf_set_i  = (vector_q == VEC_RES);
            end
            ST_VEC_HI: begin
                mem_read  = 1'b1;
                mem_addr  = vec_addr | 16'h0001;
                rf_pch_we = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy              = (state_q != ST_IDLE);
    assign rf_data           = mem_rdata;
    assign dbg_state_o       = state_q;
    assign dbg_nmi_pending_o = nmi_pending_q;

endmodule

// File: tb/tb_mc6502_interrupt_sequencer.sv
// Directed testbench for mc6502_interrupt_sequencer.
// A small vector-table memory answers reads; the bench plays the core by
// driving sync/brk/rf_* and updating rf_s by hand between pushes.

module tb_mc6502_interrupt_sequencer;

    logic        clk;
    logic        rst_x;
    logic        cen;
    logic        i_irq_x;
    logic        i_nmi_x;
    logic        sync;
    logic        brk;
    logic        rf_i;
    logic [7:0]  rf_s;
    logic [15:0] rf_pc;
    logic [7:0]  rf_psr;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        rf_set_i;
    logic        rf_s_dec;
    logic        rf_pcl_we;
    logic        rf_pch_we;
    logic [7:0]  rf_data;
    logic [2:0]  dbg_state_o;
    logic        dbg_nmi_pending_o;

    int n_cmp = 0;
    int n_err = 0;

    mc6502_interrupt_sequencer #(.STACK_PAGE(8'h01)) dut (
        .clk               (clk),
        .rst_x             (rst_x),
        .cen               (cen),
        .i_irq_x           (i_irq_x),
        .i_nmi_x           (i_nmi_x),
        .sync              (sync),
        .brk               (brk),
        .rf_i              (rf_i),
        .rf_s              (rf_s),
        .rf_pc             (rf_pc),
        .rf_psr            (rf_psr),
        .mem_rdata         (mem_rdata),
        .mem_addr          (mem_addr),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_wdata         (mem_wdata),
        .busy              (busy),
        .rf_set_i          (rf_set_i),
        .rf_s_dec          (rf_s_dec),
        .rf_pcl_we         (rf_pcl_we),
        .rf_pch_we         (rf_pch_we),
        .rf_data           (rf_data),
        .dbg_state_o       (dbg_state_o),
        .dbg_nmi_pending_o (dbg_nmi_pending_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector table: NMI=2211, RES=1234, IRQ/BRK=7856
    always_comb begin
        mem_rdata = 8'h00;
        if (mem_read) begin
            case (mem_addr)
                16'hFFFA: mem_rdata = 8'h11;
                16'hFFFB: mem_rdata = 8'h22;
                16'hFFFC: mem_rdata = 8'h34;
                16'hFFFD: mem_rdata = 8'h12;
                16'hFFFE: mem_rdata = 8'h56;
                16'hFFFF: mem_rdata = 8'h78;
                default:  mem_rdata = 8'hEE;
            endcase
        end
    end

    // Single comparison point
    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs driven afterwards reach the next edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Check the full output picture of the current cycle.
    // flags = {rf_set_i, rf_s_dec, rf_pcl_we, rf_pch_we}
    task automatic check_out(input string tag, input logic exp_busy, input logic exp_rd,
                             input logic exp_wr, input logic [15:0] exp_addr,
                             input logic [7:0] exp_wdata, input logic [7:0] exp_rdata,
                             input logic [3:0] flags);
        #1;
        check_val({tag, ".busy"},  {15'd0, busy}, {15'd0, exp_busy});
        check_val({tag, ".rd_wr"}, {14'd0, mem_read, mem_write}, {14'd0, exp_rd, exp_wr});
        check_val({tag, ".addr"},  mem_addr, exp_addr);
        check_val({tag, ".wdata"}, {8'd0, mem_wdata}, {8'd0, exp_wdata});
        check_val({tag, ".rdata"}, {8'd0, rf_data}, {8'd0, exp_rdata});
        check_val({tag, ".flags"}, {12'd0, rf_set_i, rf_s_dec, rf_pcl_we, rf_pch_we},
                  {12'd0, flags});
    endtask

    task automatic check_idle(input string tag);
        check_out(tag, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 4'b0000);
    endtask

    // Watchdog: directed flow is fixed-length, this only guards a hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_x   = 1'b0;
        cen     = 1'b1;
        i_irq_x = 1'b1;
        i_nmi_x = 1'b1;
        sync    = 1'b0;
        brk     = 1'b0;
        rf_i    = 1'b1;
        rf_s    = 8'hFF;
        rf_pc   = 16'hC003;
        rf_psr  = 8'h20;

        // ---------------- reset sequence ----------------
        repeat (2) @(posedge clk);
        #2;
        #1;
        check_val("rst.state", {13'd0, dbg_state_o}, 16'd4);
        check_val("rst.nmi_pend", {15'd0, dbg_nmi_pending_o}, 16'd0);
        rst_x = 1'b1;
        check_out("rst.vec_lo", 1'b1, 1'b1, 1'b0, 16'hFFFC, 8'h00, 8'h34, 4'b1010);
        cyc();
        check_out("rst.vec_hi", 1'b1, 1'b1, 1'b0, 16'hFFFD, 8'h00, 8'h12, 4'b0001);
        cyc();
        check_idle("rst.idle");

        // ---------------- IRQ with I clear ----------------
        i_irq_x = 1'b0;
        rf_i    = 1'b0;
        sync    = 1'b1;
        check_idle("irq.accept");
        cyc();
        sync    = 1'b0;
        i_irq_x = 1'b1;
        check_out("irq.pch", 1'b1, 1'b0, 1'b1, 16'h01FF, 8'hC0, 8'h00, 4'b0100);
        // cen low: everything holds
        cen = 1'b0;
        cyc();
        check_out("irq.hold", 1'b1, 1'b0, 1'b1, 16'h01FF, 8'hC0, 8'h00, 4'b0100);
        cen = 1'b1;
        cyc();
        rf_s = 8'hFE;
        check_out("irq.pcl", 1'b1, 1'b0, 1'b1, 16'h01FE, 8'h03, 8'h00, 4'b0100);
        cyc();
        rf_s = 8'hFD;
        check_out("irq.psr", 1'b1, 1'b0, 1'b1, 16'h01FD, 8'h20, 8'h00, 4'b1100);
        cyc();
        rf_s = 8'hFC;
        check_out("irq.vec_lo", 1'b1, 1'b1, 1'b0, 16'hFFFE, 8'h00, 8'h56, 4'b0010);
        cyc();
        check_out("irq.vec_hi", 1'b1, 1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h78, 4'b0001);
        cyc();
        check_idle("irq.done");

        // ---------------- IRQ masked by I ----------------
        rf_i    = 1'b1;
        i_irq_x = 1'b0;
        sync    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            #1;
            check_val("mask.busy_strobes", {13'd0, busy, mem_read, mem_write}, 16'd0);
        end
        i_irq_x = 1'b1;
        sync    = 1'b0;

        // ---------------- BRK ----------------
        rf_s   = 8'hFF;
        sync   = 1'b1;
        brk    = 1'b1;
        cyc();
        sync = 1'b0;
        brk  = 1'b0;
        check_out("brk.pch", 1'b1, 1'b0, 1'b1, 16'h01FF, 8'hC0, 8'h00, 4'b0100);
        cyc();
        rf_s = 8'hFE;
        cyc();
        rf_s = 8'hFD;
        check_out("brk.psr", 1'b1, 1'b0, 1'b1, 16'h01FD, 8'h30, 8'h00, 4'b1100);
        cyc();
        check_out("brk.vec_lo", 1'b1, 1'b1, 1'b0, 16'hFFFE, 8'h00, 8'h56, 4'b0010);
        cyc();
        cyc();
        check_idle("brk.done");

        // ---------------- BRK hijacked by NMI ----------------
        rf_s = 8'hFF;
        sync = 1'b1;
        brk  = 1'b1;
        cyc();
        sync    = 1'b0;
        brk     = 1'b0;
        i_nmi_x = 1'b0;
        #1;
        check_val("hij.pend_pch", {15'd0, dbg_nmi_pending_o}, 16'd0);
        cyc();
        rf_s = 8'hFE;
        #1;
        check_val("hij.pend_pcl", {15'd0, dbg_nmi_pending_o}, 16'd1);
        cyc();
        rf_s = 8'hFD;
        check_out("hij.psr", 1'b1, 1'b0, 1'b1, 16'h01FD, 8'h30, 8'h00, 4'b1100);
        cyc();
        check_out("hij.vec_lo", 1'b1, 1'b1, 1'b0, 16'hFFFA, 8'h00, 8'h11, 4'b0010);
        check_val("hij.pend_clr", {15'd0, dbg_nmi_pending_o}, 16'd0);
        cyc();
        check_out("hij.vec_hi", 1'b1, 1'b1, 1'b0, 16'hFFFB, 8'h00, 8'h22, 4'b0001);
        cyc();
        check_idle("hij.done");
        i_nmi_x = 1'b1;
        cyc();

        // ---------------- NMI held low: one sequence per edge ----------------
        rf_s    = 8'hFF;
        i_nmi_x = 1'b0;
        cyc();
        cyc();
        #1;
        check_val("nmi.pend_idle", {14'd0, busy, dbg_nmi_pending_o}, 16'd1);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check_out("nmi.pch", 1'b1, 1'b0, 1'b1, 16'h01FF, 8'hC0, 8'h00, 4'b0100);
        cyc();
        rf_s = 8'hFE;
        cyc();
        rf_s = 8'hFD;
        check_out("nmi.psr", 1'b1, 1'b0, 1'b1, 16'h01FD, 8'h20, 8'h00, 4'b1100);
        cyc();
        check_out("nmi.vec_lo", 1'b1, 1'b1, 1'b0, 16'hFFFA, 8'h00, 8'h11, 4'b0010);
        cyc();
        cyc();
        // Level still low, sync asserted: no second sequence
        sync = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            #1;
            check_val("nmi.level_once", {14'd0, busy, dbg_nmi_pending_o}, 16'd0);
        end
        sync    = 1'b0;
        i_nmi_x = 1'b1;
        cyc();
        i_nmi_x = 1'b0;
        cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        rf_s = 8'hFF;
        check_out("nmi2.pch", 1'b1, 1'b0, 1'b1, 16'h01FF, 8'hC0, 8'h00, 4'b0100);
        cyc();
        cyc();
        cyc();
        check_out("nmi2.vec_lo", 1'b1, 1'b1, 1'b0, 16'hFFFA, 8'h00, 8'h11, 4'b0010);
        cyc();
        cyc();
        check_idle("nmi2.done");
        i_nmi_x = 1'b1;
        cyc();

        // ---------------- reset during PUSH_PCL with cen low ----------------
        rf_s    = 8'hFF;
        rf_i    = 1'b0;
        i_irq_x = 1'b0;
        sync    = 1'b1;
        cyc();
        sync    = 1'b0;
        i_irq_x = 1'b1;
        cyc();
        rf_s = 8'hFE;
        check_out("rmid.pcl", 1'b1, 1'b0, 1'b1, 16'h01FE, 8'h03, 8'h00, 4'b0100);
        cen   = 1'b0;
        rst_x = 1'b0;
        cyc();
        rst_x = 1'b1;
        cen   = 1'b1;
        check_out("rmid.vec_lo", 1'b1, 1'b1, 1'b0, 16'hFFFC, 8'h00, 8'h34, 4'b1010);
        cyc();
        check_out("rmid.vec_hi", 1'b1, 1'b1, 1'b0, 16'hFFFD, 8'h00, 8'h12, 4'b0001);
        cyc();
        check_idle("rmid.done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc6502_interrupt_sequencer.md
MC6502_INTERRUPT_SEQUENCER -- requirements
Module: mc6502_interrupt_sequencer

Interface
REQ-001 Parameter: STACK_PAGE, 8'h01, high address byte for all stack pushes.
REQ-002 clk  in  1  system clock; all state changes on posedge clk.
REQ-003 rst_x  in  1  reset; synchronous, active-low.
REQ-004 cen  in  1  clock enable; state, edge detector and NMI latch advance only when cen=1.
REQ-005 i_irq_x  in  1  IRQ request, level-sensitive, active-low.
REQ-006 i_nmi_x  in  1  NMI request, falling-edge-sensitive, active-low.
REQ-007 sync  in  1  core at instruction boundary; interrupt acceptance point.
REQ-008 brk  in  1  BRK decoded; valid only with sync=1.
REQ-009 rf_i  in  1  current PSR I flag.
REQ-010 rf_s  in  8  current stack pointer.
REQ-011 rf_pc  in  16  return address to push, supplied by core.
REQ-012 rf_psr  in  8  current PSR.
REQ-013 mem_rdata  in  8  read data; valid in the same cen cycle as mem_read.
REQ-014 mem_addr  out  16  bus address.
REQ-015 mem_read / mem_write  out  1 each  bus strobes; never both high.
REQ-016 mem_wdata  out  8  write data.
REQ-017 busy  out  1  sequence in progress; core stalls while high.
REQ-018 rf_set_i  out  1  set PSR I flag.
REQ-019 rf_s_dec  out  1  decrement S by 1 this cen cycle.
REQ-020 rf_pcl_we / rf_pch_we  out  1 each  load PC low/high byte from rf_data.
REQ-021 rf_data  out  8  equals mem_rdata.

Function
REQ-022 States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_PSR, VEC_LO, VEC_HI; all outputs combinational from state and registers.
REQ-023 NMI detector: nmi_prev <= i_nmi_x each cen; nmi_prev=1 and i_nmi_x=0 sets nmi_pending.
REQ-024 nmi_pending clears on the cen cycle leaving PUSH_PSR with NMI vector selected; a new edge in that same cycle keeps it set.
REQ-025 IDLE, cen=1, sync=1: start when nmi_pending | brk | (!i_irq_x & !rf_i); next state PUSH_PCH; latch b_flag <= brk; latch vector <= NMI if nmi_pending, else IRQ/BRK.
REQ-026 IRQ not latched; deasserting before sync means no sequence; BRK ignores rf_i.
REQ-027 PUSH_PCH: mem_write=1, mem_addr={STACK_PAGE,rf_s}, mem_wdata=rf_pc[15:8], rf_s_dec=1.
REQ-028 PUSH_PCL: as PUSH_PCH with mem_wdata=rf_pc[7:0].
REQ-029 PUSH_PSR: mem_wdata = rf_psr with bit5=1, bit4=b_flag; rf_s_dec=1; rf_set_i=1.
REQ-030 Hijack: at PUSH_PSR exit, vector <= NMI if nmi_pending; b_flag unchanged.
REQ-031 VEC_LO: mem_read=1, mem_addr = FFFA (NMI), FFFC (RES), FFFE (IRQ/BRK); rf_pcl_we=1.
REQ-032 VEC_HI: mem_read=1, mem_addr = VEC_LO address + 1; rf_pch_we=1; next IDLE.
REQ-033 busy = (state != IDLE); every non-IDLE state lasts exactly one cen cycle; interrupt sequence = 5 cen cycles, reset sequence = 2.
REQ-034 In IDLE all strobes, write enables, rf_set_i and rf_s_dec are 0; mem_addr=0, mem_wdata=0.
REQ-035 cen=0: registers hold, outputs reflect held state; downstream qualifies strobes with cen.
REQ-036 sync and brk ignored while busy=1.

Reset
REQ-037 rst_x=0 at posedge clk: state=VEC_LO, vector=RES, b_flag=0, nmi_pending=0, nmi_prev=1, regardless of cen or sequence in progress.
REQ-038 While in VEC_LO with vector RES, rf_set_i=1; no stack writes occur on reset.
REQ-039 Reset mid-sequence aborts it; no further push is issued.

Verification
REQ-040 Reset release, mem FFFC=34, FFFD=12 -> two cen cycles: pcl_we data 34, pch_we data 12, then busy=0.
REQ-041 IRQ low, rf_i=0, sync, rf_s=FF, rf_pc=C003, rf_psr=20 -> writes 01FF=C0, 01FE=03, 01FD=20, reads FFFE/FFFF, rf_set_i in PUSH_PSR.
REQ-042 IRQ low with rf_i=1, sync held 10 cycles -> busy stays 0, no bus strobes.
REQ-043 brk=1, sync, rf_psr=20 -> PSR pushed as 30, vector FFFE; same with nmi falling during PUSH_PCH -> PSR 30, vector FFFA, nmi_pending then 0.
REQ-044 NMI falling edge, held low 20 cycles -> exactly one sequence at next sync, vector FFFA; second edge -> second sequence.
REQ-045 rst_x=0 during PUSH_PCL with cen=0 -> next cycle state VEC_LO, vector RES, no further writes.
